// File: rtl/fp_addsub_param.sv
// IEEE-754 add/subtract unit with configurable exponent and fraction widths.
// Handles one operation at a time and talks to the FPU fabric over stb/ack handshakes.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] input_a,
    input  logic         input_a_stb,
    output logic         input_a_ack,
    input  logic [W-1:0] input_b,
    input  logic         input_b_op,
    input  logic         input_b_stb,
    output logic         input_b_ack,
    output logic [W-1:0] output_z,
    output logic [2:0]   output_z_flags,
    output logic         output_z_stb,
    input  logic         output_z_ack
);

    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int E    = EXP_W + 2;
    localparam int M    = MAN_W + 4;

    localparam logic signed [E-1:0] E_BIAS = E'(BIAS);
    localparam logic signed [E-1:0] E_MIN  = E'(1 - BIAS);
    localparam logic signed [E-1:0] E_ZERO = E'(-BIAS);
    localparam logic signed [E-1:0] E_MAX  = E'(BIAS + 1);
    localparam logic signed [E-1:0] E_ONE  = E'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
        NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]          a, b;
    logic                  b_op;
    logic                  a_s, b_s, z_s;
    logic signed [E-1:0]   a_e, b_e, z_e;
    logic [M-1:0]          a_m, b_m;
    logic [M:0]            sum;
    logic [MAN_W:0]        z_m;
    logic                  guard, round_bit, sticky, inexact;

    function automatic logic [MAN_W+1:0] round_rne(input logic [MAN_W:0] m, input logic g,
                                                   input logic r, input logic s);
        logic [MAN_W+1:0] t;
        t = {1'b0, m};
        if (g && (r || s || m[0]))
            t = t + (MAN_W+2)'(1);
        return t;
    endfunction

    logic [MAN_W-1:0]    a_frac, b_frac;
    logic                a_zexp, b_zexp, a_nan, b_nan, a_snan, b_snan;
    logic                a_inf, b_inf, a_zero, b_zero;
    logic signed [E-1:0] a_e_adj, b_e_adj, diff;
    int                  adiff;
    logic                align_last, norm1_go, norm2_go;
    logic [MAN_W+1:0]    rnd;

    always_comb begin
        a_frac   = a_m[M-2:3];
        b_frac   = b_m[M-2:3];
        a_zexp   = (a_e == E_ZERO);
        b_zexp   = (b_e == E_ZERO);
        a_nan    = (a_e == E_MAX) && (a_frac != '0);
        b_nan    = (b_e == E_MAX) && (b_frac != '0);
        a_snan   = a_nan && !a_frac[MAN_W-1];
        b_snan   = b_nan && !b_frac[MAN_W-1];
        a_inf    = (a_e == E_MAX) && (a_frac == '0);
        b_inf    = (b_e == E_MAX) && (b_frac == '0);
        a_zero   = a_zexp && (a_frac == '0);
        b_zero   = b_zexp && (b_frac == '0);
        a_e_adj  = a_zexp ? E_MIN : a_e;
        b_e_adj  = b_zexp ? E_MIN : b_e;
        diff     = a_e - b_e;
        adiff    = (diff < 0) ? -int'(diff) : int'(diff);
        // The shift (or collapse) done this cycle is the last one when it equalises exponents.
        align_last = (adiff > MAN_W + 3) || (adiff <= 1);
        norm1_go = !z_m[MAN_W] && (z_e > E_MIN) && (z_m != '0);
        norm2_go = (z_e < E_MIN);
        rnd      = round_rne(z_m, guard, round_bit, sticky);
    end

    logic         spec_hit, spec_inv;
    logic [W-1:0] spec_z;

    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_z   = '0;
        if (a_nan || b_nan) begin
            spec_z   = QNAN;
            spec_inv = a_snan || b_snan;
        end else if (a_inf && b_inf && (a_s != b_s)) begin
            spec_z   = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_z = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_z = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_z = {a_s & b_s, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec_z = {b_s, b[W-2:0]};
        end else if (b_zero) begin
            spec_z = {a_s, a[W-2:0]};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic [EXP_W-1:0] pack_exp;
    logic [W-1:0]     pack_z;
    logic [2:0]       pack_f;

    always_comb begin
        pack_exp = EXP_W'(z_e + E_BIAS);
        pack_z   = {z_s, pack_exp, z_m[MAN_W-1:0]};
        pack_f   = {2'b00, inexact};
        if (z_e > E_BIAS) begin
            pack_z = {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_f = 3'b011;
        end else if (z_m == '0) begin
            pack_z = '0;
        end else if ((z_e == E_MIN) && !z_m[MAN_W]) begin
            pack_z = {z_s, {EXP_W{1'b0}}, z_m[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= GET_A;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GET_A:   if (input_a_ack && input_a_stb) state_nxt = GET_B;
            GET_B:   if (input_b_ack && input_b_stb) state_nxt = UNPACK;
            UNPACK:  state_nxt = SPECIAL;
            SPECIAL: begin
                if (spec_hit)
                    state_nxt = PUT_Z;
                else if (a_e_adj == b_e_adj)
                    state_nxt = ADD_0;
                else
                    state_nxt = ALIGN;
            end
            ALIGN:   if (align_last) state_nxt = ADD_0;
            ADD_0:   state_nxt = ADD_1;
            ADD_1:   state_nxt = NORM_1;
            NORM_1:  if (!norm1_go) state_nxt = NORM_2;
            NORM_2:  if (!norm2_go) state_nxt = ROUND;
            ROUND:   state_nxt = PACK;
            PACK:    state_nxt = PUT_Z;
            PUT_Z:   if (output_z_stb && output_z_ack) state_nxt = GET_A;
            default: state_nxt = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            input_a_ack    <= 1'b0;
            input_b_ack    <= 1'b0;
            output_z_stb   <= 1'b0;
            output_z       <= '0;
            output_z_flags <= '0;
        end else begin
            input_a_ack  <= (state == GET_A) && !(input_a_ack && input_a_stb);
            input_b_ack  <= (state == GET_B) && !(input_b_ack && input_b_stb);
            output_z_stb <= (state == PUT_Z) && !(output_z_stb && output_z_ack);
            if (state == SPECIAL && spec_hit) begin
                output_z       <= spec_z;
                output_z_flags <= {spec_inv, 2'b00};
            end
            if (state == PACK) begin
                output_z       <= pack_z;
                output_z_flags <= pack_f;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            GET_A: if (input_a_ack && input_a_stb) a <= input_a;
            GET_B: begin
                if (input_b_ack && input_b_stb) begin
                    b    <= input_b;
                    b_op <= input_b_op;
                end
            end
            UNPACK: begin
                a_m <= {1'b0, a[MAN_W-1:0], 3'b000};
                b_m <= {1'b0, b[MAN_W-1:0], 3'b000};
                a_e <= $signed({2'b00, a[W-2 -: EXP_W]}) - E_BIAS;
                b_e <= $signed({2'b00, b[W-2 -: EXP_W]}) - E_BIAS;
                a_s <= a[W-1];
                b_s <= b[W-1] ^ b_op;
            end
            SPECIAL: begin
                a_e      <= a_e_adj;
                b_e      <= b_e_adj;
                a_m[M-1] <= !a_zexp;
                b_m[M-1] <= !b_zexp;
            end
            ALIGN: begin
                if (a_e > b_e) begin
                    if (adiff > MAN_W + 3) begin
                        b_e <= a_e;
                        b_m <= {{(M-1){1'b0}}, |b_m};
                    end else begin
                        b_e <= b_e + E_ONE;
                        b_m <= {1'b0, b_m[M-1:2], |b_m[1:0]};
                    end
                end else if (b_e > a_e) begin
                    if (adiff > MAN_W + 3) begin
                        a_e <= b_e;
                        a_m <= {{(M-1){1'b0}}, |a_m};
                    end else begin
                        a_e <= a_e + E_ONE;
                        a_m <= {1'b0, a_m[M-1:2], |a_m[1:0]};
                    end
                end
            end
            ADD_0: begin
                z_e <= a_e;
                if (a_s == b_s) begin
                    sum <= {1'b0, a_m} + {1'b0, b_m};
                    z_s <= a_s;
                end else if (a_m >= b_m) begin
                    sum <= {1'b0, a_m} - {1'b0, b_m};
                    z_s <= a_s;
                end else begin
                    sum <= {1'b0, b_m} - {1'b0, a_m};
                    z_s <= b_s;
                end
            end
            ADD_1: begin
                if (sum[M]) begin
                    z_m       <= sum[M:4];
                    guard     <= sum[3];
                    round_bit <= sum[2];
                    sticky    <= sum[1] | sum[0];
                    z_e       <= z_e + E_ONE;
                end else begin
                    z_m       <= sum[M-1:3];
                    guard     <= sum[2];
                    round_bit <= sum[1];
                    sticky    <= sum[0];
                end
            end
            NORM_1: begin
                if (norm1_go) begin
                    z_e       <= z_e - E_ONE;
                    z_m       <= {z_m[MAN_W-1:0], guard};
                    guard     <= round_bit;
                    round_bit <= 1'b0;
                end
            end
            NORM_2: begin
                if (norm2_go) begin
                    z_e       <= z_e + E_ONE;
                    z_m       <= {1'b0, z_m[MAN_W:1]};
                    guard     <= z_m[0];
                    round_bit <= guard;
                    sticky    <= sticky | round_bit;
                end
            end
            ROUND: begin
                inexact <= guard | round_bit | sticky;
                // All-ones rollover becomes 1.000 at the next exponent.
                if (rnd[MAN_W+1]) begin
                    z_m <= {1'b1, {MAN_W{1'b0}}};
                    z_e <= z_e + E_ONE;
                end else begin
                    z_m <= rnd[MAN_W:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/fp_addsub_param.md
# fp_addsub_param

Parametrised IEEE-754 binary floating-point add/subtract unit, the successor to the team's single-precision adder. Exponent and mantissa widths are generics, so one block serves half, single and double precision. The block adds a per-transaction add/subtract select, full IEEE special-case handling, and exception flags (invalid, overflow, inexact). It sits on the same three-channel stb/ack stream fabric as the other FPU blocks and processes one operation at a time.

## Interface
- EXP_W, default 8: exponent field width; must be ≥ 3.
- MAN_W, default 23: stored fraction width, without the hidden bit; must be ≥ 2.
- W = 1+EXP_W+MAN_W (derived, not overridable): operand/result width.
- BIAS = 2^(EXP_W-1)-1 (derived).
- Ports:
  - clk, input, 1: single clock; all logic on rising edge.
  - rst_n, input, 1: reset, synchronous, active-low.
  - input_a, input, W: operand A.
  - input_a_stb, input, 1: A valid.
  - input_a_ack, output, 1: A ready.
  - input_b, input, W: operand B.
  - input_b_op, input, 1: 0 = A+B, 1 = A−B; sampled with B.
  - input_b_stb, input, 1: B valid.
  - input_b_ack, output, 1: B ready.
  - output_z, output, W: result.
  - output_z_flags, output, 3: {invalid, overflow, inexact}; valid with output_z.
  - output_z_stb, output, 1: result valid.
  - output_z_ack, input, 1: result accepted.

## Operation
- **States:** GET_A → GET_B → UNPACK → SPECIAL → ALIGN → ADD_0 → ADD_1 → NORM_1 → NORM_2 → ROUND → PACK → PUT_Z → GET_A. SPECIAL jumps straight to PUT_Z for special results.
- **Operand capture:**
  - GET_A: registers ack = 1. A transfer occurs on an edge with ack && stb; the block latches A, drops ack the next cycle and moves on.
  - GET_B: same handshake; latches input_b and input_b_op.
- **UNPACK:**
  - Mantissa widened to MAN_W+4 bits: hidden bit, fraction, then 3 guard/round/sticky zeros.
  - Exponent held signed in EXP_W+2 bits.
  - Effective B sign = b_s XOR op.
- **SPECIAL, in priority order:**
  1. Either operand NaN → canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0). Invalid is set only if an operand is a signalling NaN.
  2. Inf + inf of opposite effective sign → canonical qNaN, invalid = 1.
  3. Either operand inf → that inf, with its effective sign.
  4. Both zero → zero with sign a_s AND b_eff_s.
  5. One operand zero → the other operand unchanged, with its effective sign.
  6. Otherwise: a subnormal operand gets exponent 1−BIAS and hidden bit 0; a normal operand gets hidden bit 1.
- **ALIGN:**
  - Each cycle, the smaller-exponent operand shifts right 1 and its exponent increments; shifted-out bits OR into bit 0 (sticky).
  - If the exponent difference exceeds MAN_W+3, the smaller mantissa collapses in one cycle to the value 1 (sticky only, when nonzero) and its exponent is set equal to the larger.
  - Leave ALIGN when the exponents are equal.
- **ADD_0:** same effective signs → add; different → subtract smaller magnitude from larger, result takes the larger operand's sign. The sum is MAN_W+5 bits.
- **ADD_1:** on carry-out, take the top MAN_W+1 bits, derive guard/round/sticky below them, and increment the exponent.
- **NORM_1:** while hidden bit = 0 and exponent > 1−BIAS, shift left 1 per cycle; the guard bit feeds the LSB.
- **NORM_2:** while exponent < 1−BIAS, shift right 1 per cycle, accumulating sticky.
- **ROUND:**
  - Round-to-nearest-even: increment when guard && (round | sticky | lsb).
  - An all-ones mantissa rolls over and increments the exponent.
  - Inexact = guard | round | sticky.
- **PACK:**
  - Hidden bit 0 at minimum exponent → exponent field 0 (subnormal).
  - Exact zero from cancellation → +0.
  - Exponent > BIAS → ±inf, with overflow = 1 and inexact = 1.
- **PUT_Z:** present result and flags; see Timing for the handshake and return.

## Timing
- **Reset values:** rst_n low at an edge → state GET_A; input_a_ack, input_b_ack, output_z_stb = 0; output_z and output_z_flags = 0.
- **Reset priority:** reset overrides any in-flight state, including mid-ALIGN and PUT_Z; the pending result is discarded.
- **Ack timing:** ack rises 1 cycle after entering GET_A or GET_B, so minimum 2 cycles per operand.
- **Latency:** from B-transfer edge to output_z_stb high:
  - Special cases: 3 cycles.
  - General case: 9 + align_shifts + norm_shifts cycles.
  - align_shifts ≤ MAN_W+4.
  - norm_shifts ≤ MAN_W+1 in NORM_1, plus the NORM_2 right-shifts.
- **Output hold:** output_z_stb stays high, with output_z and flags stable, until the edge where output_z_ack = 1. stb drops on the next cycle and the state returns to GET_A.
- **Ack without stb:** output_z_ack high while stb is low is ignored.
- **Early stb:** input stb asserted before ack is held until ack; no data is lost and no double capture occurs.

## Test plan
- Default parameters, 0x3F800000 + 0x40000000, op = 0 → 0x40400000, flags 000. Repeat with op = 1 on 0x3F800000 − 0x3F800000 → 0x00000000 (+0), flags 000.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, flags 100. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 011.
- 0x3F800000 + 0x30800000 → 0x3F800000, flags 001. Check that the align collapse path completes ALIGN in ≤ 2 cycles.
- Subnormals: 0x00000001 + 0x00000001 → 0x00000002. Separately, 0x00800000 − 0x007FFFFF → 0x00000001, flags 000.
- EXP_W = 5, MAN_W = 10: 0x3C00 + 0x3C00 → 0x4000. 0x7BFF + 0x7BFF → 0x7C00, flags 011.
- Handshake and reset:
  - Hold output_z_ack low 20 cycles → output_z stable, stb high throughout.
  - Pulse rst_n low during ALIGN → next cycle all acks/stb = 0, state GET_A, and the next transaction computes correctly.
